nibble_serial_accumulator: RTL and testbench
============================================

NIBBLE_SERIAL_ACCUMULATOR -- requirements
Module: nibble_serial_accumulator

Interface
REQ-001 Parameter: ACC_W, default 8; accumulator width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand offered.
REQ-005 Port: in_ready  output  1  block can accept an operand.
REQ-006 Port: in_data  input  4  unsigned operand to add.
REQ-007 Port: in_clr  input  1  qualified by in_valid; treat the accumulator as zero before adding.
REQ-008 Port: out_valid  output  1  result available.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: acc  output  ACC_W  accumulated sum.
REQ-011 Port: ovf  output  1  sticky wrap-around flag.

Function
REQ-012 The block SHALL use one clock and an asynchronous, active-low reset (rst_n).
REQ-013 The FSM SHALL have states IDLE, ADD (iterating nibble index k = 0 .. ACC_W/4-1), and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with rst_n high; in_valid SHALL be ignored in every other state.
REQ-015 An operand SHALL be accepted on an edge where in_valid and in_ready are both 1; accept latches in_data and in_clr and moves to ADD with k = 0 and carry = 0.
REQ-016 If the latched in_clr = 1, acc SHALL be cleared to zero and ovf SHALL be cleared to 0 on the accept edge.
REQ-017 Each ADD cycle SHALL compute nibble k as acc[4k+3:4k] + B + carry with one 4-bit add, where B = latched operand for k = 0 and 4'b0000 otherwise. The sum SHALL be written back to nibble k, and the carry-out SHALL be registered for nibble k+1.
REQ-018 After the last nibble (k = ACC_W/4-1), the FSM SHALL move to DONE; a final carry-out of 1 SHALL set ovf on that same edge.
REQ-019 The result SHALL wrap modulo 2^ACC_W, and ovf SHALL stay 1 until reset or an accepted in_clr.
REQ-020 Latency: out_valid SHALL assert ACC_W/4 + 1 cycles after the accept edge (3 cycles for ACC_W = 8).
REQ-021 out_valid SHALL be 1 exactly in DONE.
REQ-022 acc and ovf SHALL be held stable while out_valid = 1 and out_ready = 0, for any duration.
REQ-023 The FSM SHALL return to IDLE on the edge where out_valid = 1 and out_ready = 1; in_ready is 1 the following cycle.
REQ-024 An operand SHALL NOT be accepted in the same cycle as a result handshake; peak throughput is one operand per ACC_W/4 + 2 cycles.
REQ-025 acc SHALL show intermediate nibble updates during ADD; consumers SHALL only sample acc when out_valid = 1.

Reset
REQ-026 While rst_n = 0: state = IDLE, acc = 0, carry = 0, ovf = 0, out_valid = 0, in_ready = 0, all applied immediately without waiting for a clock edge.
REQ-027 Reset asserted mid-ADD or in DONE SHALL abort the operation with no partial result retained.
REQ-028 On the first rising clk edge after rst_n deasserts, in_ready SHALL be 1 and no operand SHALL be accepted on that edge.

Verification (ACC_W = 8)
REQ-029 Reset, then accept 4'h5 with in_clr = 0 -> out_valid = 1 three cycles later with acc = 8'h05 and ovf = 0.
REQ-030 acc = 8'h0F, accept 4'h1 -> acc = 8'h10 (carry crosses nibble boundary), ovf = 0.
REQ-031 From reset, accept 4'hF seventeen times -> acc = 8'hFF with ovf = 0; an eighteenth 4'hF -> acc = 8'h0E with ovf = 1, and ovf remains 1 after a further 4'h1.
REQ-032 acc = 8'h0E with ovf = 1, accept 4'h3 with in_clr = 1 -> acc = 8'h03 and ovf = 0.
REQ-033 Hold out_ready = 0 for 5 cycles in DONE while driving in_valid = 1 -> acc, ovf and out_valid are unchanged, in_ready = 0 and nothing is accepted; raise out_ready -> IDLE next cycle.
REQ-034 Assert rst_n = 0 during the second ADD cycle -> acc, ovf and out_valid go to 0 immediately; after release, in_ready = 1 and a new accept of 4'h2 yields acc = 8'h02.

Source files
------------

// File: rtl/nibble_serial_accumulator.sv
// nibble_serial_accumulator: adds a 4-bit operand into an ACC_W-bit accumulator one nibble per cycle
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_data is the operand, in_clr zeroes acc and ovf first
//   out_valid/out_ready   result handshake; acc and ovf are held while out_valid is waiting
//   acc                   accumulated sum, wraps modulo 2^ACC_W
//   ovf                   sticky wrap-around flag
module nibble_serial_accumulator #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);
  localparam int N = ACC_W / 4;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic [3:0] b;
  logic [4:0] sum;
  logic carry, armed, accept, last;
  always_comb begin
    in_ready = state == IDLE && rst_n;
    out_valid = state == DONE;
    // armed blocks acceptance on the first edge after reset release
    accept = in_valid && in_ready && armed;
    last = k == K_LAST;
    // only nibble 0 receives the operand; higher nibbles just absorb the carry
    sum = {1'b0, acc[{k, 2'b00} +: 4]} + {1'b0, k == '0 ? b : 4'h0} + 5'(carry);
    state_nxt = state == IDLE ? (accept ? ADD : IDLE) :
                state == ADD  ? (last ? DONE : ADD) :
                                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
      carry <= 1'b0;
      k <= '0;
      b <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        b <= in_data;
        k <= '0;
        carry <= 1'b0;
        if (in_clr) begin
          acc <= '0;
          ovf <= 1'b0;
        end
      end else if (state == ADD) begin
        acc[{k, 2'b00} +: 4] <= sum[3:0];
        carry <= sum[4];
        k <= k + KW'(1);
        if (last && sum[4]) ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// tb_nibble_serial_accumulator: directed checks of the nibble-serial accumulator at ACC_W = 8
module tb_nibble_serial_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_data = 4'h0;
  logic in_clr = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] acc;
  logic ovf;
  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  nibble_serial_accumulator #(.ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_clr(in_clr), .out_valid(out_valid),
    .out_ready(out_ready), .acc(acc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // offer one operand from IDLE and wait (bounded) for the result; lat numbers the
  // cycles after the accept edge, the first being 1
  task automatic run(input logic [3:0] d, input logic c, output int l);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_clr = c;
    @(posedge clk); #1;
    in_valid = 1'b0; in_clr = 1'b0;
    l = 1;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic handshake;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_handshake", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic op(input string tag, input logic [3:0] d, input logic c, input logic [7:0] ea, input logic eo);
    run(d, c, lat);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_acc"}, acc, ea);
    chk({tag, "_ovf"}, ovf, eo);
    handshake();
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    // first edge after release must not accept even with in_valid high
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'h7;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_edge_no_accept", {in_ready, acc}, {1'b1, 8'h00});
    @(posedge clk); #1;
    chk("first_edge_still_idle", {in_ready, out_valid}, 2'b10);
    op("add5", 4'h5, 1'b0, 8'h05, 1'b0);
    op("addA", 4'hA, 1'b0, 8'h0F, 1'b0);
    op("carry", 4'h1, 1'b0, 8'h10, 1'b0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run(4'hF, 1'b0, lat);
      chk("f17_lat", lat, 3);
      handshake();
    end
    chk("f17_acc", acc, 8'hFF);
    chk("f17_ovf", ovf, 0);
    op("f18", 4'hF, 1'b0, 8'h0E, 1'b1);
    op("sticky", 4'h1, 1'b0, 8'h0F, 1'b1);
    op("clr", 4'h3, 1'b1, 8'h03, 1'b0);
    // result held while consumer stalls; in_valid ignored outside IDLE
    run(4'h9, 1'b0, lat);
    chk("hold_lat", lat, 3);
    in_valid = 1'b1; in_data = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_state", {out_valid, in_ready, ovf, acc}, {3'b100, 8'h0C});
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release", {out_valid, in_ready, acc}, {2'b01, 8'h0C});
    // abort during the second ADD cycle
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'h7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_add_partial", acc, 8'h03);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_immediate", {out_valid, ovf, acc}, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    op("after_abort", 4'h2, 1'b0, 8'h02, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
